// File: rtl/systolic_scheduler.sv
// systolic_scheduler
//   Sequences one matrix job on an N x N systolic array: a weight preload
//   phase (bottom weight row first so it shifts furthest), then a compute
//   phase that streams K data rows with one cycle of skew per array row,
//   then a one-cycle done pulse.
//
//   Optional feature: define SCHED_PERF_CNT_EN to build a saturating 32-bit
//   busy-cycle counter on perf_cycles; otherwise perf_cycles is tied to 0.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   start         one-cycle job request, only looked at in IDLE
//   abort         synchronous cancel, wins over everything else
//   num_vectors   data row count K, latched when start is accepted
//   wt_rd_en      weight buffer read strobe
//   wt_rd_addr    weight buffer row address (decoded from state)
//   data_rd_en    data buffer read strobe
//   data_rd_addr  data buffer row address (decoded from state)
//   load_weight   per-row weight load strobe
//   enable_mult   per-row multiply enable
//   out_valid     per-column result valid
//   busy          high whenever the FSM is not in IDLE
//   done          one-cycle completion pulse
//   perf_cycles   busy-cycle count of the last/current job
//
// State   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start
// LOAD_W  | N cycles of weight reads, k = N-1 .. 0 on the address
// COMPUTE | K+2N-1 cycles: data feed, skewed multiply, skewed output
// DONE    | single-cycle done pulse, then back to IDLE

module systolic_scheduler #(
    parameter int MATRIX_SIZE = 2,
    parameter int VEC_W       = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           abort,
    input  logic [VEC_W-1:0]               num_vectors,
    output logic                           wt_rd_en,
    output logic [$clog2(MATRIX_SIZE)-1:0] wt_rd_addr,
    output logic                           data_rd_en,
    output logic [VEC_W-1:0]               data_rd_addr,
    output logic [MATRIX_SIZE-1:0]         load_weight,
    output logic [MATRIX_SIZE-1:0]         enable_mult,
    output logic [MATRIX_SIZE-1:0]         out_valid,
    output logic                           busy,
    output logic                           done,
    output logic [31:0]                    perf_cycles
);

    localparam int N  = MATRIX_SIZE;
    localparam int KW = $clog2(MATRIX_SIZE);
    localparam int TW = VEC_W + 1;   // t must reach K+2N-2 without wrapping
    localparam int XW = VEC_W + 2;   // headroom for window bound sums

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD_W  = 2'd1,
        COMPUTE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [TW-1:0]     t_q, t_d;
    logic [VEC_W-1:0]  kv_q, kv_d;
    logic [TW-1:0]     t_last;

    logic              wt_rd_en_d;
    logic              data_rd_en_d;
    logic [N-1:0]      load_weight_d;
    logic [N-1:0]      enable_mult_d;
    logic [N-1:0]      out_valid_d;
    logic              busy_d;
    logic              done_d;

    assign t_last = {1'b0, kv_q} + TW'(2 * N - 2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            t_q     <= '0;
            kv_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            t_q     <= t_d;
            kv_q    <= kv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        t_d     = t_q;
        kv_d    = kv_q;
        if (abort) begin
            state_d = IDLE;
            k_d     = '0;
            t_d     = '0;
            kv_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = LOAD_W;
                        k_d     = '0;
                        t_d     = '0;
                        kv_d    = num_vectors;
                    end
                end
                LOAD_W: begin
                    if (k_q == KW'(N - 1)) begin
                        k_d     = '0;
                        t_d     = '0;
                        state_d = (kv_q == '0) ? DONE : COMPUTE;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
                COMPUTE: begin
                    if (t_q == t_last) begin
                        t_d     = '0;
                        state_d = DONE;
                    end else begin
                        t_d = t_q + TW'(1);
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Strobes are registered, so they are decoded from the next state and
    // next counters; that keeps them cycle-aligned with the registered state.
    always_comb begin
        logic [XW-1:0] tx;
        logic [XW-1:0] kx;
        wt_rd_en_d    = 1'b0;
        data_rd_en_d  = 1'b0;
        load_weight_d = '0;
        enable_mult_d = '0;
        out_valid_d   = '0;
        tx            = {1'b0, t_d};
        kx            = {2'b00, kv_d};
        case (state_d)
            LOAD_W: begin
                wt_rd_en_d    = 1'b1;
                load_weight_d = '1;
            end
            COMPUTE: begin
                data_rd_en_d = (tx < kx);
                for (int i = 0; i < N; i++) begin
                    enable_mult_d[i] = (tx >= XW'(i)) && (tx < XW'(i) + kx);
                    out_valid_d[i]   = (tx >= XW'(N + i)) && (tx < XW'(N + i) + kx);
                end
            end
            default: begin
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wt_rd_en    <= 1'b0;
            data_rd_en  <= 1'b0;
            load_weight <= '0;
            enable_mult <= '0;
            out_valid   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            wt_rd_en    <= wt_rd_en_d;
            data_rd_en  <= data_rd_en_d;
            load_weight <= load_weight_d;
            enable_mult <= enable_mult_d;
            out_valid   <= out_valid_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

    // Addresses are pure decodes of registered state; parked at 0 when idle.
    assign wt_rd_addr = (state_q == LOAD_W) ? (KW'(N - 1) - k_q) : '0;

    always_comb begin
        data_rd_addr = '0;
        if (state_q == COMPUTE) begin
            if (t_q < {1'b0, kv_q}) begin
                data_rd_addr = t_q[VEC_W-1:0];
            end else begin
                data_rd_addr = kv_q - VEC_W'(1);
            end
        end
    end

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] perf_q;
    logic        start_ok;

    assign start_ok = (state_q == IDLE) && start && !abort;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_q <= '0;
        end else if (start_ok) begin
            perf_q <= '0;
        end else if (busy && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_systolic_scheduler.sv
// tb_systolic_scheduler
//   Scoreboard bench for systolic_scheduler. Each issued job pushes its
//   whole expected per-cycle output trace into a queue; a monitor samples
//   the DUT 2 time units after every rising edge and compares against the
//   queue head, or against the all-idle picture when the queue is empty.
//   Build with +define+SCHED_PERF_CNT_EN to also check the perf counter.

module tb_systolic_scheduler;

    localparam int N     = 2;
    localparam int VEC_W = 16;
    localparam int KW    = $clog2(N);
`ifdef SCHED_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic              start;
    logic              abort;
    logic [VEC_W-1:0]  num_vectors;
    logic              wt_rd_en;
    logic [KW-1:0]     wt_rd_addr;
    logic              data_rd_en;
    logic [VEC_W-1:0]  data_rd_addr;
    logic [N-1:0]      load_weight;
    logic [N-1:0]      enable_mult;
    logic [N-1:0]      out_valid;
    logic              busy;
    logic              done;
    logic [31:0]       perf_cycles;

    systolic_scheduler #(
        .MATRIX_SIZE (N),
        .VEC_W       (VEC_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .num_vectors  (num_vectors),
        .wt_rd_en     (wt_rd_en),
        .wt_rd_addr   (wt_rd_addr),
        .data_rd_en   (data_rd_en),
        .data_rd_addr (data_rd_addr),
        .load_weight  (load_weight),
        .enable_mult  (enable_mult),
        .out_valid    (out_valid),
        .busy         (busy),
        .done         (done),
        .perf_cycles  (perf_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        wt_en;
        logic [15:0] wt_addr;
        logic        d_en;
        logic [15:0] d_addr;
        logic [15:0] lw;
        logic [15:0] em;
        logic [15:0] ov;
        logic        busy;
        logic        done;
        logic [31:0] perf;
    } obs_t;

    obs_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] idle_perf = 32'd0;

    function automatic obs_t idle_obs(logic [31:0] p);
        obs_t o;
        o      = '0;
        o.perf = PERF_EN ? p : 32'd0;
        return o;
    endfunction

    function automatic obs_t sample_dut();
        obs_t o;
        o         = '0;
        o.wt_en   = wt_rd_en;
        o.wt_addr = 16'(wt_rd_addr);
        o.d_en    = data_rd_en;
        o.d_addr  = 16'(data_rd_addr);
        o.lw      = 16'(load_weight);
        o.em      = 16'(enable_mult);
        o.ov      = 16'(out_valid);
        o.busy    = busy;
        o.done    = done;
        o.perf    = perf_cycles;
        return o;
    endfunction

    function automatic void check(string name, obs_t a, obs_t e);
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s @%0t: actual wt=%0b/%0d data=%0b/%0d lw=%h em=%h ov=%h busy=%0b done=%0b perf=%0d | required wt=%0b/%0d data=%0b/%0d lw=%h em=%h ov=%h busy=%0b done=%0b perf=%0d",
                     name, $time,
                     a.wt_en, a.wt_addr, a.d_en, a.d_addr, a.lw, a.em, a.ov, a.busy, a.done, a.perf,
                     e.wt_en, e.wt_addr, e.d_en, e.d_addr, e.lw, e.em, e.ov, e.busy, e.done, e.perf);
        end
    endfunction

    function automatic int job_len(int kv);
        return N + ((kv > 0) ? kv + 2 * N - 1 : 0) + 1;
    endfunction

    // Reference trace: weight rows bottom-up, then data row r reaches array
    // row i at compute cycle r+i and leaves column j at compute cycle N+j+r.
    function automatic void push_job(int kv);
        int   lc;
        int   len;
        obs_t tr[];
        lc  = (kv > 0) ? kv + 2 * N - 1 : 0;
        len = job_len(kv);
        tr  = new[len];
        for (int c = 0; c < len; c++) begin
            tr[c]      = '0;
            tr[c].busy = 1'b1;
            tr[c].perf = PERF_EN ? 32'(c) : 32'd0;
        end
        for (int c = 0; c < N; c++) begin
            tr[c].wt_en   = 1'b1;
            tr[c].wt_addr = 16'(N - 1 - c);
            tr[c].lw      = 16'((1 << N) - 1);
        end
        for (int t = 0; t < lc; t++) begin
            tr[N + t].d_en   = (t < kv);
            tr[N + t].d_addr = 16'((t < kv) ? t : kv - 1);
        end
        for (int r = 0; r < kv; r++) begin
            for (int i = 0; i < N; i++) begin
                tr[N + r + i].em[i]     = 1'b1;
                tr[N + N + i + r].ov[i] = 1'b1;
            end
        end
        tr[len - 1].done = 1'b1;
        for (int c = 0; c < len; c++) exp_q.push_back(tr[c]);
    endfunction

    // Monitor
    initial begin
        obs_t a;
        obs_t e;
        forever begin
            @(posedge clk);
            #2;
            a = sample_dut();
            if (exp_q.size() > 0) begin
                e         = exp_q.pop_front();
                idle_perf = e.perf + 32'd1;
            end else begin
                e = idle_obs(idle_perf);
            end
            check("cycle_outputs", a, e);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual sim time %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic idle_cycles(int n);
        start = 1'b0;
        abort = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge with the DUT in IDLE; returns at the negedge of
    // the IDLE cycle following done. Start/num_vectors are scrambled while
    // busy to show they are ignored outside IDLE.
    task automatic run_job(int kv, bit hold);
        int len;
        len         = job_len(kv);
        start       = 1'b1;
        abort       = 1'b0;
        num_vectors = VEC_W'(kv);
        push_job(kv);
        for (int c = 0; c <= len; c++) begin
            @(negedge clk);
            if (c < len) begin
                start       = hold ? 1'b1 : 1'($urandom_range(0, 1));
                num_vectors = VEC_W'($urandom);
            end
        end
    endtask

    // Abort raised in busy cycle cyc (1 = first LOAD_W cycle).
    task automatic abort_after(int kv, int cyc);
        start       = 1'b1;
        abort       = 1'b0;
        num_vectors = VEC_W'(kv);
        push_job(kv);
        @(negedge clk);
        start = 1'b0;
        repeat (cyc - 1) @(negedge clk);
        abort = 1'b1;
        exp_q.delete();
        @(negedge clk);
        abort = 1'b0;
    endtask

    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        num_vectors = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        idle_cycles(2);

        run_job(3, 1'b0);
        idle_cycles(2);
        run_job(0, 1'b0);
        idle_cycles(1);

        run_job(1, 1'b1);
        run_job(1, 1'b1);
        idle_cycles(2);

        abort_after(4, N + 2);
        idle_cycles(1);
        run_job(2, 1'b0);
        idle_cycles(1);

        abort_after(3, 1);
        idle_cycles(1);

        start       = 1'b1;
        abort       = 1'b1;
        num_vectors = VEC_W'(3);
        @(negedge clk);
        idle_cycles(2);

        // asynchronous reset in the middle of COMPUTE (t = 1)
        start       = 1'b1;
        num_vectors = VEC_W'(4);
        push_job(4);
        @(negedge clk);
        start = 1'b0;
        repeat (N + 1) @(negedge clk);
        #2;
        reset = 1'b0;
        exp_q.delete();
        idle_perf = 32'd0;
        #1;
        check("async_reset_outputs", sample_dut(), idle_obs(32'd0));
        repeat (3) @(negedge clk);
        reset = 1'b1;
        idle_cycles(4);

        repeat (20) begin
            run_job($urandom_range(0, 7), 1'($urandom_range(0, 1)));
            idle_cycles($urandom_range(0, 2));
        end
        run_job(20, 1'b0);
        idle_cycles(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_scheduler.md
SYSTOLIC_SCHEDULER -- requirements
Module: systolic_scheduler

Interface
REQ-001 Parameter MATRIX_SIZE, default 2: array dimension N; legal range is 2 to 16.
REQ-002 Parameter VEC_W, default 16: width of the vector count and the data address.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to run one job; sampled in IDLE only.
REQ-006 abort  input  1  synchronous job cancel.
REQ-007 num_vectors  input  VEC_W  input row count K; latched on the start cycle.
REQ-008 wt_rd_en  output  1  weight buffer read strobe.
REQ-009 wt_rd_addr  output  $clog2(N)  weight buffer row address.
REQ-010 data_rd_en  output  1  data buffer read strobe.
REQ-011 data_rd_addr  output  VEC_W  data buffer row address.
REQ-012 load_weight  output  N  per-row weight-load strobe to the array.
REQ-013 enable_mult  output  N  per-row multiply enable to the array.
REQ-014 out_valid  output  N  per-column result-valid flag.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle job-complete pulse.
REQ-017 perf_cycles  output  32  busy-cycle count (see Configuration).

Function
REQ-018 The FSM SHALL have states IDLE, LOAD_W, COMPUTE and DONE, held in a registered state.
REQ-019 IDLE with start=1 SHALL latch K and go to LOAD_W; start in any other state SHALL be ignored.
REQ-020 LOAD_W SHALL last exactly N cycles, where k is the cycle index 0..N-1.
REQ-021 In LOAD_W cycle k: wt_rd_en=1, wt_rd_addr=N-1-k, load_weight=all ones.
REQ-022 The weight buffer has zero read latency; the bottom row is read first so it shifts furthest.
REQ-023 After LOAD_W, K=0 SHALL go directly to DONE; otherwise the FSM SHALL go to COMPUTE with counter t=0.
REQ-024 COMPUTE SHALL last T=K+2N-1 cycles, with t=0..T-1, then go to DONE.
REQ-025 In COMPUTE, data_rd_en SHALL be 1 and data_rd_addr=t for t<K; otherwise data_rd_en=0 and data_rd_addr holds K-1.
REQ-026 enable_mult[i] SHALL be 1 iff i<=t<=i+K-1 (row skew of one cycle per row).
REQ-027 out_valid[j] SHALL be 1 iff N+j<=t<=N+j+K-1.
REQ-028 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-029 All strobes SHALL be 0 outside the states and windows named above.
REQ-030 abort=1 in any state SHALL force IDLE on the next edge, with done not asserted; abort has priority over start and over every state transition.
REQ-031 The t counter SHALL be VEC_W+1 bits wide so that T cannot wrap for K up to 2^VEC_W-1.
REQ-032 All outputs SHALL be registered except wt_rd_addr and data_rd_addr, which SHALL be decoded from registered state and counters only.

Reset
REQ-033 While reset=0: the FSM SHALL be in IDLE; k, t and the latched K SHALL be 0; every output SHALL be 0, including perf_cycles.
REQ-034 Reset assertion mid-job SHALL discard the job immediately; after reset release the block SHALL wait for a new start.

Configuration
REQ-035 Macro SCHED_PERF_CNT_EN, when defined, SHALL compile in a 32-bit counter.
REQ-036 With SCHED_PERF_CNT_EN defined: the counter SHALL clear on an accepted start, increment on every cycle with busy=1, saturate at 2^32-1, and hold its value in IDLE.
REQ-037 Without SCHED_PERF_CNT_EN: perf_cycles SHALL be tied to 0 and no counter logic SHALL exist.

Verification
REQ-038 N=2, K=3, start at cycle 0 -> LOAD_W in cycles 1-2 with wt_rd_addr 1 then 0 and load_weight=2'b11; enable_mult[0] high for t0-2; enable_mult[1] high for t1-3; out_valid[0] high for t2-4; out_valid[1] high for t3-5; done one cycle after t=5.
REQ-039 N=2, K=0 -> two LOAD_W cycles, then done; enable_mult, data_rd_en and out_valid never asserted.
REQ-040 start held high continuously for two back-to-back jobs with K=1 -> second job accepted only on the cycle after done (IDLE); busy=1 for exactly 2+1+3+1=7 cycles per job.
REQ-041 abort at t=1 of a K=4 job -> IDLE next cycle; all strobes 0; done never asserted; a new start is accepted normally.
REQ-042 reset driven low asynchronously mid-COMPUTE -> all outputs 0 without a clock edge; block stays in IDLE after release until start.
REQ-043 With SCHED_PERF_CNT_EN defined, N=4, K=5 -> perf_cycles=4+12+1=17 after done; without the macro, perf_cycles=0 throughout.
